// File: rtl/imem_fetch_unit_if.sv
// Fetch / program-load bus of imem_fetch_unit. The master side is the fetch
// stage and program loader; the slave side is the instruction memory.
interface imem_fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic              fetch_ready;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic              inst_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;
  logic              init_done;
  logic              parity_err;

  modport master (
    output fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
    input  fetch_ready, inst_valid, inst, inst_fault, prog_err, init_done, parity_err
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, prog_we, prog_addr, prog_data,
    output fetch_ready, inst_valid, inst, inst_fault, prog_err, init_done, parity_err
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction memory with registered fetch port, program-load port and a
// self-initialising fill FSM. Optional per-word even parity: IMEM_PARITY_EN.
module imem_fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hE300_0000
) (
  input logic               clk,
  input logic               rst,
  imem_fetch_unit_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  fill_cnt_r;
  logic              inst_valid_r;
  logic [DATA_W-1:0] inst_r;
  logic              inst_fault_r;
  logic              prog_err_r;
  logic              init_done_r;
  logic              parity_err_r;
  logic [MEM_W-1:0]  mem_r [DEPTH];

  logic              fetch_bad_s;
  logic              prog_bad_s;
  logic              fetch_ready_s;
  logic              accept_s;
  logic [MEM_W-1:0]  rd_word_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_widx_s;
  logic [MEM_W-1:0]  mem_wdata_s;

  // Misaligned or beyond the last word: any address bit above the index set.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
  endfunction

`ifdef IMEM_PARITY_EN
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef IMEM_PARITY_EN
    return {even_par(d), d};
`else
    return d;
`endif
  endfunction

  // Address decode, fetch acceptance and the single memory write port mux.
  always_comb begin
    fetch_bad_s   = addr_bad(bus.fetch_addr);
    prog_bad_s    = addr_bad(bus.prog_addr);
    fetch_ready_s = (state_r == RUN) && !bus.prog_we && !(inst_valid_r && bus.stall);
    accept_s      = bus.fetch_req && fetch_ready_s;
    rd_word_s     = mem_r[bus.fetch_addr[IDX_W+1:2]];
    if (state_r == INIT) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = fill_cnt_r;
      mem_wdata_s = pack_word(NOP_WORD);
    end else begin
      mem_we_s    = bus.prog_we && !prog_bad_s;
      mem_widx_s  = bus.prog_addr[IDX_W+1:2];
      mem_wdata_s = pack_word(bus.prog_data);
    end
  end

  // Storage array; contents are rebuilt by the fill walk after every reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Fill FSM plus registered fetch outputs and program-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= INIT;
      fill_cnt_r   <= '0;
      inst_valid_r <= 1'b0;
      inst_r       <= '0;
      inst_fault_r <= 1'b0;
      prog_err_r   <= 1'b0;
      init_done_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      prog_err_r <= bus.prog_we && ((state_r != RUN) || prog_bad_s);
      case (state_r)
        INIT: begin
          fill_cnt_r <= fill_cnt_r + 1'b1;
          if (fill_cnt_r == IDX_W'(DEPTH - 1)) begin
            state_r     <= RUN;
            init_done_r <= 1'b1;
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r    <= INIT;
          fill_cnt_r <= '0;
        end
      endcase
      // A stalled valid word holds; otherwise the output tracks acceptance.
      if (inst_valid_r && bus.stall) begin
        inst_valid_r <= 1'b1;
      end else if (accept_s) begin
        inst_valid_r <= 1'b1;
        if (fetch_bad_s) begin
          inst_r       <= NOP_WORD;
          inst_fault_r <= 1'b1;
          parity_err_r <= 1'b0;
        end else begin
          inst_r       <= rd_word_s[DATA_W-1:0];
          inst_fault_r <= 1'b0;
`ifdef IMEM_PARITY_EN
          parity_err_r <= rd_word_s[DATA_W] != even_par(rd_word_s[DATA_W-1:0]);
`else
          parity_err_r <= 1'b0;
`endif
        end
      end else begin
        inst_valid_r <= 1'b0;
        parity_err_r <= 1'b0;
      end
    end
  end

  assign bus.fetch_ready = fetch_ready_s;
  assign bus.inst_valid  = inst_valid_r;
  assign bus.inst        = inst_r;
  assign bus.inst_fault  = inst_fault_r;
  assign bus.prog_err    = prog_err_r;
  assign bus.init_done   = init_done_r;
`ifdef IMEM_PARITY_EN
  assign bus.parity_err  = parity_err_r;
`else
  assign bus.parity_err  = 1'b0;
`endif
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: vector table for the per-cycle
// handshake, scoreboard queue for fetched words, hand sequences for resets.
module tb_imem_fetch_unit;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 64;
  localparam int          IW     = $clog2(DEPTH);
  localparam logic [31:0] NOP    = 32'hE300_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  imem_fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        stall;
    logic        exp_ready;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        fault;
    logic        perr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_inst;
  logic        m_fault;
  logic        m_perr;
  int          corrupt_idx = -1;
  int          total = 0;
  int          bad   = 0;
  vec_t        vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit addr_good(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
  endfunction

  task automatic idle_inputs(input logic stl);
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 32'h0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = 32'h0;
    bus.prog_data  = 32'h0;
    bus.stall      = stl;
  endtask

  task automatic apply_row(input vec_t v, input string name);
    exp_t e;
    bit   acc;
    int   idx;
    bus.fetch_req  = v.req;
    bus.fetch_addr = v.addr;
    bus.prog_we    = v.we;
    bus.prog_addr  = v.paddr;
    bus.prog_data  = v.pdata;
    bus.stall      = v.stall;
    #1;
    chk({name, ".fetch_ready"}, {31'b0, bus.fetch_ready}, {31'b0, v.exp_ready});
    acc = v.req && v.exp_ready;
    if (acc) begin
      idx = int'(v.addr[IW+1:2]);
      if (addr_good(v.addr)) begin
        e.inst  = (idx == corrupt_idx) ? (model_mem[idx] ^ 32'h1) : model_mem[idx];
        e.fault = 1'b0;
        e.perr  = (idx == corrupt_idx);
      end else begin
        e.inst  = NOP;
        e.fault = 1'b1;
        e.perr  = 1'b0;
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v.we && addr_good(v.paddr)) begin
      model_mem[v.paddr[IW+1:2]] = v.pdata;
      if (int'(v.paddr[IW+1:2]) == corrupt_idx) corrupt_idx = -1;
    end
    chk({name, ".prog_err"}, {31'b0, bus.prog_err}, {31'b0, v.exp_err});
    if (m_valid && v.stall) begin
      m_valid = 1'b1;
    end else if (acc) begin
      e       = sb_q.pop_front();
      m_valid = 1'b1;
      m_inst  = e.inst;
      m_fault = e.fault;
      m_perr  = e.perr;
    end else begin
      m_valid = 1'b0;
    end
    chk({name, ".inst_valid"}, {31'b0, bus.inst_valid}, {31'b0, m_valid});
    chk({name, ".inst"}, bus.inst, m_inst);
    if (m_valid) begin
      chk({name, ".inst_fault"}, {31'b0, bus.inst_fault}, {31'b0, m_fault});
      chk({name, ".parity_err"}, {31'b0, bus.parity_err}, {31'b0, m_perr});
    end
  endtask

  task automatic do_reset(input string name, input logic stl);
    idle_inputs(stl);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk({name, ".fetch_ready"}, {31'b0, bus.fetch_ready}, 32'h0);
    chk({name, ".inst_valid"}, {31'b0, bus.inst_valid}, 32'h0);
    chk({name, ".inst"}, bus.inst, 32'h0);
    chk({name, ".inst_fault"}, {31'b0, bus.inst_fault}, 32'h0);
    chk({name, ".prog_err"}, {31'b0, bus.prog_err}, 32'h0);
    chk({name, ".init_done"}, {31'b0, bus.init_done}, 32'h0);
    chk({name, ".parity_err"}, {31'b0, bus.parity_err}, 32'h0);
    sb_q.delete();
    m_valid     = 1'b0;
    m_inst      = 32'h0;
    m_fault     = 1'b0;
    m_perr      = 1'b0;
    corrupt_idx = -1;
    idle_inputs(1'b0);
    rst = 1'b0;
  endtask

  task automatic fill_wait(input string name);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    chk({name, ".ready_in_init"}, {31'b0, bus.fetch_ready}, 32'h0);
    for (int i = 0; i < 2 * DEPTH + 8 && !done; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.init_done) done = 1'b1;
    end
    chk({name, ".fill_cycles"}, n, DEPTH);
    chk({name, ".ready_after_fill"}, {31'b0, bus.fetch_ready}, 32'h1);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
  endtask

  initial begin
    vec_t v;
    idle_inputs(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset("reset", 1'b0);
    fill_wait("fill");

    //           req   addr          we    paddr         pdata          stall rdy  err
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 32'h6500_0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0004, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0006, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_0004, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0008, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0008, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_00FC, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_00FC, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_0008, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 32'h0000_000C, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 32'h0000_000C, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 32'h0000_000C, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 32'h0000_000C, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 24; i++) begin
      apply_row(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a word is held under stall.
    v = '{1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    apply_row(v, "pre_stall_fetch");
    v = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    apply_row(v, "stall_hold");
    do_reset("reset_in_stall", 1'b1);
    fill_wait("refill_after_stall");

    // Reset in the middle of the fill, after a write dropped during INIT.
    do_reset("reset_pre_midfill", 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 32'h0;
    bus.prog_data = 32'h1111_1111;
    @(posedge clk);
    #1;
    chk("init_write.prog_err", {31'b0, bus.prog_err}, 32'h1);
    chk("init_write.init_done", {31'b0, bus.init_done}, 32'h0);
    do_reset("reset_midfill", 1'b0);
    fill_wait("refill_midfill");

    // Earlier program writes must be gone after the refill.
    v = '{1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    apply_row(v, "post_refill_0x4");
    v = '{1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    apply_row(v, "post_refill_0x0");

`ifdef IMEM_PARITY_EN
    v = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    apply_row(v, "par_idle");
    dut.mem_r[3] = dut.mem_r[3] ^ 33'h1;
    corrupt_idx = 3;
    v = '{1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    apply_row(v, "par_corrupt_fetch");
    v = '{1'b0, 32'h0, 1'b1, 32'h0000_000C, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0};
    apply_row(v, "par_rewrite");
    v = '{1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    apply_row(v, "par_clean_fetch");
`endif

    v = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    apply_row(v, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
